// File: rtl/dual_port_ram_param.sv
// Simple dual-port RAM: one write port with byte-lane enables, one read port with 1- or 2-cycle
// registered read, read-first/write-first collision policy, and an optional zero-fill sweep after reset.
module dual_port_ram_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int BYTE_WIDTH    = 8,
  parameter int READ_LATENCY  = 1,
  parameter int RW_MODE       = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             read_enable,
  input  logic [ADDR_WIDTH-1:0]            read_address,
  input  logic                             write_enable,
  input  logic [ADDR_WIDTH-1:0]            write_address,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] write_byte_en,
  output logic [DATA_WIDTH-1:0]            read_data,
  output logic                             read_valid,
  output logic                             collision,
  output logic                             init_done
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NUM_BE = DATA_WIDTH / BYTE_WIDTH;

  typedef enum logic [1:0] {RST, INIT, READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   sweep_addr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    rd_go;
  logic                    wr_go;
  logic                    rw_hit;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign rd_go  = (state == READY) && read_enable;
  assign wr_go  = (state == READY) && write_enable;
  assign rw_hit = rd_go && wr_go && (read_address == write_address);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RST;
      sweep_addr <= '0;
      init_done  <= (INIT_ON_RESET == 0);
    end else begin
      case (state)
        RST: begin
          if (INIT_ON_RESET != 0) begin
            state <= INIT;
          end else begin
            state     <= READY;
            init_done <= 1'b1;
          end
        end
        INIT: begin
          sweep_addr <= sweep_addr + 1'b1;
          if (&sweep_addr) begin
            state     <= READY;
            init_done <= 1'b1;
          end
        end
        READY: state <= READY;
        default: state <= RST;
      endcase
    end
  end

  // Storage has no reset: only the sweep or an accepted write changes it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        mem[sweep_addr] <= '0;
      end else if (wr_go) begin
        for (int i = 0; i < NUM_BE; i++) begin
          if (write_byte_en[i]) begin
            mem[write_address][i*BYTE_WIDTH +: BYTE_WIDTH] <= write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  // Write-first forwards the enabled lanes of a same-address write into the read word.
  always_comb begin
    rd_word = mem[read_address];
    if ((RW_MODE != 0) && rw_hit) begin
      for (int i = 0; i < NUM_BE; i++) begin
        if (write_byte_en[i]) begin
          rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s1_data;
      logic                  s1_vld;
      logic                  s1_coll;

      // The word is captured when the read is accepted, so later writes cannot disturb it.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_data    <= '0;
          s1_vld     <= 1'b0;
          s1_coll    <= 1'b0;
          read_data  <= '0;
          read_valid <= 1'b0;
          collision  <= 1'b0;
        end else begin
          s1_vld     <= rd_go;
          s1_coll    <= rw_hit;
          if (rd_go) s1_data <= rd_word;
          read_valid <= s1_vld;
          collision  <= s1_coll;
          if (s1_vld) read_data <= s1_data;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          read_data  <= '0;
          read_valid <= 1'b0;
          collision  <= 1'b0;
        end else begin
          read_valid <= rd_go;
          collision  <= rw_hit;
          if (rd_go) read_data <= rd_word;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Bench for dual_port_ram_param: one default instance (8-bit, latency 1, read-first, zero-fill)
// and one 16-bit instance (latency 2, write-first, no sweep); reads are scored through queues.
module tb_dual_port_ram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  logic        a_rst_n, a_re, a_we;
  logic [7:0]  a_ra, a_wa, a_wd, a_rd;
  logic [0:0]  a_be;
  logic        a_rv, a_co, a_id;

  logic        b_rst_n, b_re, b_we;
  logic [7:0]  b_ra, b_wa;
  logic [15:0] b_wd, b_rd;
  logic [1:0]  b_be;
  logic        b_rv, b_co, b_id;

  dual_port_ram_param u_a (
    .clk(clk), .rst_n(a_rst_n),
    .read_enable(a_re), .read_address(a_ra),
    .write_enable(a_we), .write_address(a_wa), .write_data(a_wd), .write_byte_en(a_be),
    .read_data(a_rd), .read_valid(a_rv), .collision(a_co), .init_done(a_id)
  );

  dual_port_ram_param #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .BYTE_WIDTH(8),
    .READ_LATENCY(2), .RW_MODE(1), .INIT_ON_RESET(0)
  ) u_b (
    .clk(clk), .rst_n(b_rst_n),
    .read_enable(b_re), .read_address(b_ra),
    .write_enable(b_we), .write_address(b_wa), .write_data(b_wd), .write_byte_en(b_be),
    .read_data(b_rd), .read_valid(b_rv), .collision(b_co), .init_done(b_id)
  );

  typedef struct {
    logic [15:0] d;
    logic        c;
    int          at;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  typedef struct {
    bit          dut;
    bit          we;
    logic [7:0]  wa;
    logic [15:0] wd;
    logic [1:0]  be;
    bit          re;
    logic [7:0]  ra;
    logic [15:0] ed;
    bit          ec;
  } vec_t;

  localparam int NV = 25;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic idle();
    a_re = 1'b0; a_we = 1'b0; a_ra = '0; a_wa = '0; a_wd = '0; a_be = '0;
    b_re = 1'b0; b_we = 1'b0; b_ra = '0; b_wa = '0; b_wd = '0; b_be = '0;
  endtask

  // Called just after a falling edge; the read is accepted on the next rising edge.
  task automatic drive(input vec_t v);
    idle();
    if (!v.dut) begin
      a_we = v.we; a_wa = v.wa; a_wd = v.wd[7:0]; a_be = v.be[0:0];
      a_re = v.re; a_ra = v.ra;
      if (v.re) qa.push_back('{v.ed, v.ec, cyc + 1});
    end else begin
      b_we = v.we; b_wa = v.wa; b_wd = v.wd; b_be = v.be;
      b_re = v.re; b_ra = v.ra;
      if (v.re) qb.push_back('{v.ed, v.ec, cyc + 2});
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (qa.size() > 0 && qa[0].at < cyc) begin
      chk("a_read_valid_cycle", cyc, qa[0].at);
      void'(qa.pop_front());
    end
    if (a_rv) begin
      if (qa.size() == 0) chk("a_unexpected_read_valid", a_rv, 0);
      else begin
        e = qa.pop_front();
        chk("a_read_valid_cycle", cyc, e.at);
        chk("a_read_data", a_rd, e.d);
        chk("a_collision", a_co, e.c);
      end
    end else if (a_co) chk("a_collision_without_valid", a_co, 0);
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (qb.size() > 0 && qb[0].at < cyc) begin
      chk("b_read_valid_cycle", cyc, qb[0].at);
      void'(qb.pop_front());
    end
    if (b_rv) begin
      if (qb.size() == 0) chk("b_unexpected_read_valid", b_rv, 0);
      else begin
        e = qb.pop_front();
        chk("b_read_valid_cycle", cyc, e.at);
        chk("b_read_data", b_rd, e.d);
        chk("b_collision", b_co, e.c);
      end
    end else if (b_co) chk("b_collision_without_valid", b_co, 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rel;
    int rise;
    vec_t rd1b;

    vt = '{
      '{0, 0, 8'h00, 16'h0000, 2'b00, 1, 8'h1B, 16'h0000, 0},
      '{0, 0, 8'h00, 16'h0000, 2'b00, 1, 8'h02, 16'h0000, 0},
      '{0, 1, 8'h1B, 16'h003B, 2'b01, 0, 8'h00, 16'h0000, 0},
      '{0, 1, 8'h1C, 16'h003D, 2'b01, 0, 8'h00, 16'h0000, 0},
      '{0, 0, 8'h00, 16'h0000, 2'b00, 1, 8'h1B, 16'h003B, 0},
      '{0, 1, 8'h1B, 16'h0055, 2'b01, 1, 8'h1B, 16'h003B, 1},
      '{0, 0, 8'h00, 16'h0000, 2'b00, 1, 8'h1B, 16'h0055, 0},
      '{0, 0, 8'h00, 16'h0000, 2'b00, 1, 8'h1C, 16'h003D, 0},
      '{0, 1, 8'h1C, 16'h0077, 2'b00, 1, 8'h1C, 16'h003D, 1},
      '{0, 0, 8'h00, 16'h0000, 2'b00, 1, 8'h1C, 16'h003D, 0},
      '{0, 1, 8'h40, 16'h00F0, 2'b01, 1, 8'h41, 16'h0000, 0},
      '{0, 0, 8'h00, 16'h0000, 2'b00, 1, 8'h40, 16'h00F0, 0},
      '{1, 1, 8'h05, 16'h1234, 2'b11, 0, 8'h00, 16'h0000, 0},
      '{1, 1, 8'h05, 16'hABCD, 2'b10, 0, 8'h00, 16'h0000, 0},
      '{1, 0, 8'h00, 16'h0000, 2'b00, 1, 8'h05, 16'hAB34, 0},
      '{1, 1, 8'h1B, 16'h003B, 2'b11, 0, 8'h00, 16'h0000, 0},
      '{1, 1, 8'h1C, 16'h003D, 2'b11, 0, 8'h00, 16'h0000, 0},
      '{1, 0, 8'h00, 16'h0000, 2'b00, 1, 8'h1B, 16'h003B, 0},
      '{1, 0, 8'h00, 16'h0000, 2'b00, 1, 8'h1C, 16'h003D, 0},
      '{1, 1, 8'h1B, 16'h0055, 2'b11, 1, 8'h1B, 16'h0055, 1},
      '{1, 1, 8'h1B, 16'h9999, 2'b10, 1, 8'h1B, 16'h9955, 1},
      '{1, 0, 8'h00, 16'h0000, 2'b00, 1, 8'h1C, 16'h003D, 0},
      '{1, 1, 8'h1C, 16'h1111, 2'b11, 0, 8'h00, 16'h0000, 0},
      '{1, 0, 8'h00, 16'h0000, 2'b00, 1, 8'h1C, 16'h1111, 0},
      '{1, 1, 8'h1C, 16'hFFFF, 2'b00, 1, 8'h1C, 16'h1111, 1}
    };
    rd1b = '{0, 0, 8'h00, 16'h0000, 2'b00, 1, 8'h1B, 16'h0000, 0};

    idle();
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_init_done_in_reset", a_id, 0);
    chk("a_read_valid_in_reset", a_rv, 0);
    chk("a_read_data_in_reset", a_rd, 0);
    chk("a_collision_in_reset", a_co, 0);
    chk("b_init_done_in_reset", b_id, 1);
    chk("b_read_data_in_reset", b_rd, 0);

    // Release; the sweep counts edges from the first edge that samples rst_n high.
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    rel  = cyc;
    rise = -1;
    for (int k = 0; k < 400 && rise < 0; k++) begin
      @(negedge clk);
      if (a_id) rise = cyc;
      idle();
      if (cyc == rel + 10) begin
        a_we = 1'b1; a_wa = 8'h02; a_wd = 8'hAA; a_be = 1'b1;
        a_re = 1'b1; a_ra = 8'h02;
      end
    end
    idle();
    chk("a_init_done_edges", rise - (rel + 1), 256);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i]);
    end
    @(negedge clk);
    idle();
    repeat (4) @(negedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    // Reset in the middle of a sweep restarts it from address 0.
    a_rst_n = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1;
    rel = cyc;
    chk("a_read_data_after_reset", a_rd, 0);
    chk("a_init_done_after_reset", a_id, 0);
    while (cyc < rel + 100) @(negedge clk);
    a_rst_n = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1;
    rel  = cyc;
    rise = -1;
    chk("a_init_done_mid_sweep_reset", a_id, 0);
    for (int k = 0; k < 400 && rise < 0; k++) begin
      @(negedge clk);
      if (a_id) rise = cyc;
    end
    chk("a_init_done_edges_restart", rise - (rel + 1), 256);

    drive(rd1b);
    @(negedge clk);
    idle();
    repeat (4) @(negedge clk);
    chk("a_queue_drained_final", qa.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_param.md
Name: dual_port_ram_param

Overview:
Parametrised simple dual-port RAM, the successor to the fixed 8x256 two-port memory used under the FIFO. It has one write port and one read port on a single clock. New features: byte-lane write enables, a selectable read latency of 1 or 2, a defined read-during-write policy with a collision flag, a read_valid strobe, and an optional zero-fill sweep after reset. The FIFO controller and future buffering blocks instantiate it as their storage.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of BYTE_WIDTH.
ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words.
BYTE_WIDTH, 8, bits per write-enable lane; NUM_BE = DATA_WIDTH/BYTE_WIDTH.
READ_LATENCY, 1, cycles from accepted read to data; legal values 1 or 2.
RW_MODE, 0, same-address read/write policy: 0 = read-first (old data), 1 = write-first (new data).
INIT_ON_RESET, 1, 1 = zero-fill every word after reset; 0 = no sweep, init_done high out of reset.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst_n  in  1  reset, synchronous, active-low.
read_enable  in  1  read request.
read_address  in  ADDR_WIDTH  read word address.
write_enable  in  1  write request.
write_address  in  ADDR_WIDTH  write word address.
write_data  in  DATA_WIDTH  write word.
write_byte_en  in  NUM_BE  per-lane write mask; bit i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH].
read_data  out  DATA_WIDTH  registered read word.
read_valid  out  1  one-cycle strobe marking new read_data.
collision  out  1  one-cycle strobe, aligned with read_valid, for a same-address read/write.
init_done  out  1  high when the RAM accepts requests.

Behaviour:
- Reset (rst_n low at a posedge):
  - read_data=0, read_valid=0, collision=0, read pipeline cleared.
  - init_done=0 if INIT_ON_RESET=1, else 1.
  - Memory contents are not altered by reset itself.
- Init FSM, states RST, INIT, READY:
  - RST -> INIT on the first edge with rst_n high when INIT_ON_RESET=1; otherwise RST -> READY.
  - INIT writes all-zero to address 0, 1, ... DEPTH-1, one word per cycle, taking exactly DEPTH cycles.
  - INIT -> READY after the write to DEPTH-1; init_done rises on that same edge.
  - While not READY, read_enable and write_enable are ignored: no memory write, no read_valid.
  - rst_n low in any state returns the FSM to RST; the sweep restarts from address 0.
- Write (READY, write_enable=1 at edge N):
  - For each i with write_byte_en[i]=1, lane i of mem[write_address] takes write_data lane i.
  - Other lanes are unchanged; write_byte_en=0 writes nothing.
- Read (READY, read_enable=1 at edge N):
  - read_data is updated on edge N+READ_LATENCY; read_valid=1 for exactly that cycle.
  - read_data holds its last value when no read completes; it is never cleared except by reset.
  - Throughput is 1 read/cycle; back-to-back reads produce consecutive read_valid cycles.
- Collision (READY, read and write both enabled, read_address==write_address, same edge):
  - RW_MODE=0: the read returns the pre-write word.
  - RW_MODE=1: the read returns the merged word (enabled lanes new, others old).
  - collision=1 alongside that read's read_valid, including when write_byte_en=0 (data is then the old word).
- READ_LATENCY=2: the word is captured at edge N+1 and output at N+2. A write at edge N+1 to the same address does not affect the in-flight read and raises no collision.
- Addresses are always in range (DEPTH=2**ADDR_WIDTH); wrap-around is handled by the caller.

Test Plan:
1. Defaults; release rst_n -> init_done rises exactly 256 cycles later; read 8'h1B -> read_data=8'h00 one cycle later, read_valid pulses 1 cycle.
2. Defaults; write 8'h3B to 8'h1B, then 8'h3D to 8'h1C, then read 8'h1B -> read_data=8'h3B with read_valid at the next edge, collision=0.
3. DATA_WIDTH=16; write 16'h1234 to addr 5 with be=2'b11, then 16'hABCD with be=2'b10; read 5 -> 16'hAB34.
4. 8'h1B holds 8'h3B; same-cycle write 8'h55 and read of 8'h1B -> RW_MODE=0 gives 8'h3B with collision=1, and a following read gives 8'h55; RW_MODE=1 gives 8'h55 with collision=1.
5. READ_LATENCY=2; reads of 8'h1B then 8'h1C on edges N and N+1 -> 8'h3B at N+2 and 8'h3D at N+3, read_valid high for both cycles.
6. Defaults; rst_n low for one cycle at sweep cycle 100 -> init_done rises 256 cycles after release; a write issued at sweep cycle 10 is not retained (reads back 0).
